al_sch_queue: RTL and testbench

AL_SCH_QUEUE -- requirements
Module: al_sch_queue

---
 rtl/al_sch_queue_pkg.sv | 21 ++
 rtl/al_sch_queue_ptr.sv | 23 ++
 rtl/al_sch_queue.sv | 110 +++++++++++
 tb/tb_al_sch_queue.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/al_sch_queue_pkg.sv
// Shared allocation/scheduler definitions: slot width, lane count,
// loop sideband layout and the bundle carried from allocation to the scheduler.
package al_sch_queue_pkg;

   localparam int INST_W = 56;
   localparam int LANES  = 4;
   localparam int LBD_W  = 2;
   localparam int SB_W   = LBD_W + 2;

   typedef struct packed {
      logic [LBD_W-1:0] lbd_state;
      logic             fnsh_unrll;
      logic             loop_strt;
   } sideband_t;

   typedef struct packed {
      logic [LANES-1:0][INST_W-1:0] slot;
      sideband_t                    sb;
   } bundle_t;

endpackage

// File: rtl/al_sch_queue_ptr.sv
// Wrapping pointer: clears on clr, advances by one on inc, wraps at 2**W.
module al_sch_queue_ptr #(
   parameter int W = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] ptr
);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples its inputs from before the edge, independent of process order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         ptr <= '0;
      else if (clr)
         ptr <= '0;
      else if (inc)
         ptr <= ptr + 1'b1;
   end

endmodule

// File: rtl/al_sch_queue.sv
// Allocation-to-scheduler bundle queue: a DEPTH-entry circular buffer of
// 4-wide renamed bundles with their loop sideband, 1-cycle minimum latency.
module al_sch_queue #(
   parameter int DEPTH  = 4,
   parameter int INST_W = 56
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [INST_W-1:0]           inst_in0,
   input  logic [INST_W-1:0]           inst_in1,
   input  logic [INST_W-1:0]           inst_in2,
   input  logic [INST_W-1:0]           inst_in3,
   input  logic                        all_nop_in,
   input  logic [1:0]                  lbd_state_in,
   input  logic                        fnsh_unrll_in,
   input  logic                        loop_strt_in,
   input  logic                        flush,
   input  logic                        sch_full,
   output logic [INST_W-1:0]           inst_out0,
   output logic [INST_W-1:0]           inst_out1,
   output logic [INST_W-1:0]           inst_out2,
   output logic [INST_W-1:0]           inst_out3,
   output logic                        out_valid,
   output logic [1:0]                  lbd_state_out,
   output logic                        fnsh_unrll_out,
   output logic                        loop_strt_out,
   output logic                        full_to_al,
   output logic [$clog2(DEPTH):0]      count
);

   import al_sch_queue_pkg::*;

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [LANES-1:0][INST_W-1:0] slot_mem [DEPTH];
   sideband_t                    sb_mem   [DEPTH];

   logic [PTR_W-1:0] head;
   logic [PTR_W-1:0] tail;
   logic             push;
   logic             pop;

   // Status comes from the count register only, so allocation and the
   // scheduler never see a combinational path from their own requests.
   assign full_to_al = (count == CNT_W'(DEPTH));
   assign out_valid  = (count != '0);

   assign push = !all_nop_in && !full_to_al && !flush;
   assign pop  = out_valid && !sch_full && !flush;

   al_sch_queue_ptr #(.W(PTR_W)) u_head_ptr (
      .clk (clk),
      .rst (rst),
      .clr (flush),
      .inc (pop),
      .ptr (head)
   );

   al_sch_queue_ptr #(.W(PTR_W)) u_tail_ptr (
      .clk (clk),
      .rst (rst),
      .clr (flush),
      .inc (push),
      .ptr (tail)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         count <= '0;
      else if (flush)
         count <= '0;
      else if (push && !pop)
         count <= count + 1'b1;
      else if (pop && !push)
         count <= count - 1'b1;
   end

   // NOTE: the storage array has no reset; stale entries are unreachable
   // because head/tail/count reset, and outputs are gated by out_valid.
   always_ff @(posedge clk) begin
      if (push) begin
         slot_mem[tail] <= {inst_in3, inst_in2, inst_in1, inst_in0};
         sb_mem[tail]   <= '{lbd_state: lbd_state_in,
                             fnsh_unrll: fnsh_unrll_in,
                             loop_strt: loop_strt_in};
      end
   end

   // NOTE: every output gets a default first so no path infers a latch.
   always_comb begin
      inst_out0      = '0;
      inst_out1      = '0;
      inst_out2      = '0;
      inst_out3      = '0;
      lbd_state_out  = '0;
      fnsh_unrll_out = 1'b0;
      loop_strt_out  = 1'b0;
      if (out_valid) begin
         inst_out0      = slot_mem[head][0];
         inst_out1      = slot_mem[head][1];
         inst_out2      = slot_mem[head][2];
         inst_out3      = slot_mem[head][3];
         lbd_state_out  = sb_mem[head].lbd_state;
         fnsh_unrll_out = sb_mem[head].fnsh_unrll;
         loop_strt_out  = sb_mem[head].loop_strt;
      end
   end

endmodule

// File: tb/tb_al_sch_queue.sv
// Randomized and directed bench for al_sch_queue: a bundle-level FIFO model
// feeds a scoreboard that a negedge monitor compares against the DUT outputs.
module tb_al_sch_queue;

   import al_sch_queue_pkg::*;

   localparam int DEPTH = 4;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              all_nop_in;
   logic              flush;
   logic              sch_full;
   bundle_t           drv_b;
   logic [INST_W-1:0] inst_out0, inst_out1, inst_out2, inst_out3;
   logic              out_valid;
   logic [1:0]        lbd_state_out;
   logic              fnsh_unrll_out;
   logic              loop_strt_out;
   logic              full_to_al;
   logic [2:0]        count;

   int checks = 0;
   int errors = 0;

   bundle_t exp_q[$];
   bit      acc;
   bit      m_push, m_pop;
   bundle_t mon_got, mon_exp;

   always #5 clk = ~clk;

   al_sch_queue #(.DEPTH(DEPTH), .INST_W(INST_W)) dut (
      .clk            (clk),
      .rst            (rst),
      .inst_in0       (drv_b.slot[0]),
      .inst_in1       (drv_b.slot[1]),
      .inst_in2       (drv_b.slot[2]),
      .inst_in3       (drv_b.slot[3]),
      .all_nop_in     (all_nop_in),
      .lbd_state_in   (drv_b.sb.lbd_state),
      .fnsh_unrll_in  (drv_b.sb.fnsh_unrll),
      .loop_strt_in   (drv_b.sb.loop_strt),
      .flush          (flush),
      .sch_full       (sch_full),
      .inst_out0      (inst_out0),
      .inst_out1      (inst_out1),
      .inst_out2      (inst_out2),
      .inst_out3      (inst_out3),
      .out_valid      (out_valid),
      .lbd_state_out  (lbd_state_out),
      .fnsh_unrll_out (fnsh_unrll_out),
      .loop_strt_out  (loop_strt_out),
      .full_to_al     (full_to_al),
      .count          (count)
   );

   task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
      end
   endtask

   // Reference model: a bundle FIFO updated at each edge from the offered inputs.
   always begin
      @(posedge clk or posedge rst);
      if (rst) begin
         exp_q.delete();
         acc = 1'b0;
      end else begin
         m_push = !all_nop_in && (exp_q.size() < DEPTH) && !flush;
         m_pop  = (exp_q.size() != 0) && !sch_full && !flush;
         acc    = m_push;
         if (flush)
            exp_q.delete();
         else begin
            if (m_pop)  void'(exp_q.pop_front());
            if (m_push) exp_q.push_back(drv_b);
         end
      end
   end

   // Monitor: head bundle (or all-zero when empty) and status every cycle.
   always @(negedge clk) begin
      mon_got.slot[0] = inst_out0;
      mon_got.slot[1] = inst_out1;
      mon_got.slot[2] = inst_out2;
      mon_got.slot[3] = inst_out3;
      mon_got.sb      = '{lbd_state: lbd_state_out, fnsh_unrll: fnsh_unrll_out,
                          loop_strt: loop_strt_out};
      mon_exp = (exp_q.size() != 0) ? exp_q[0] : '0;
      check("count", count, exp_q.size());
      check("out_valid", out_valid, exp_q.size() != 0);
      check("full_to_al", full_to_al, exp_q.size() == DEPTH);
      check(exp_q.size() != 0 ? "head_bundle" : "idle_zero", mon_got, mon_exp);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic bundle_t rand_b();
      bundle_t b;
      for (int i = 0; i < LANES; i++) b.slot[i] = INST_W'({$urandom(), $urandom()});
      b.sb = SB_W'($urandom());
      return b;
   endfunction

   task automatic send(input bundle_t b);
      drv_b      = b;
      all_nop_in = 1'b0;
      for (int i = 0; i < 40; i++) begin
         step();
         if (acc) begin
            all_nop_in = 1'b1;
            return;
         end
      end
      checks++;
      errors++;
      $display("FAIL send_timeout bundle not accepted within 40 cycles t=%0t", $time);
      all_nop_in = 1'b1;
   endtask

   task automatic drain();
      all_nop_in = 1'b1;
      sch_full   = 1'b0;
      flush      = 1'b0;
      for (int i = 0; i < 40 && exp_q.size() != 0; i++) step();
      step();
      check("drained_count", count, 0);
   endtask

   bundle_t b;

   initial begin
      all_nop_in = 1'b1;
      flush      = 1'b0;
      sch_full   = 1'b0;
      drv_b      = '0;
      #1;
      check("rst_count", count, 0);
      check("rst_out_valid", out_valid, 0);
      repeat (2) step();
      rst = 1'b0;
      step();

      // Single bundle, 1-cycle latency, popped with sch_full=0.
      b = '0;
      b.slot[0] = 56'h1;
      send(b);
      check("A_valid", out_valid, 1);
      check("A_slot0", inst_out0, 56'h1);
      step();
      check("A_popped_count", count, 0);
      drain();

      // Fill to full, hold a fifth bundle, then drain in order.
      sch_full = 1'b1;
      for (int i = 0; i < 4; i++) send(rand_b());
      check("full_count", count, 4);
      check("full_flag", full_to_al, 1);
      b = rand_b();
      drv_b = b;
      all_nop_in = 1'b0;
      repeat (3) step();
      check("E_not_written", count, 4);
      sch_full = 1'b0;
      send(b);
      drain();

      // Steady push+pop at count=2 for 6 cycles, tail wraps.
      sch_full = 1'b1;
      send(rand_b());
      send(rand_b());
      sch_full = 1'b0;
      for (int i = 0; i < 6; i++) begin
         send(rand_b());
         check("steady_count", count, 2);
      end
      drain();

      // Flush at count=3 while offering bundle F.
      sch_full = 1'b1;
      for (int i = 0; i < 3; i++) send(rand_b());
      drv_b = rand_b();
      all_nop_in = 1'b0;
      flush = 1'b1;
      step();
      flush = 1'b0;
      all_nop_in = 1'b1;
      check("flush_count", count, 0);
      check("flush_valid", out_valid, 0);
      check("flush_out0", inst_out0, 0);
      drain();

      // all_nop bundle drops its sideband; the next real bundle keeps its own.
      sch_full = 1'b1;
      b = rand_b();
      b.sb = '{lbd_state: 2'd2, fnsh_unrll: 1'b0, loop_strt: 1'b0};
      send(b);
      b = rand_b();
      b.sb.loop_strt = 1'b1;
      drv_b = b;
      all_nop_in = 1'b1;
      repeat (3) step();
      check("nop_count", count, 1);
      check("nop_loop_strt", loop_strt_out, 0);
      b = rand_b();
      b.sb = '{lbd_state: 2'd1, fnsh_unrll: 1'b1, loop_strt: 1'b1};
      send(b);
      drain();

      // Asynchronous reset between edges at count=3.
      sch_full = 1'b1;
      for (int i = 0; i < 3; i++) send(rand_b());
      #2 rst = 1'b1;
      #1;
      check("arst_count", count, 0);
      check("arst_valid", out_valid, 0);
      check("arst_out0", inst_out0, 0);
      check("arst_lbd", lbd_state_out, 0);
      rst = 1'b0;
      sch_full = 1'b0;
      send(rand_b());
      drain();

      // Randomized traffic.
      drv_b = rand_b();
      for (int i = 0; i < 400; i++) begin
         sch_full   = ($urandom_range(0, 9) < 4);
         flush      = ($urandom_range(0, 49) == 0);
         all_nop_in = ($urandom_range(0, 9) < 3);
         step();
         if (acc) drv_b = rand_b();
      end
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
